// File: rtl/wb_regfile.sv
// wb_regfile: write-back GPR array, HI/LO pair and retired-write counter.
// Define WB_BYPASS_EN to forward same-cycle writes to the read ports.
module wb_regfile #(
    parameter int NREG  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [4:0]       waddr,
    input  logic [31:0]      wdata,
    input  logic             re1,
    input  logic [4:0]       raddr1,
    output logic [31:0]      rdata1,
    input  logic             re2,
    input  logic [4:0]       raddr2,
    output logic [31:0]      rdata2,
    input  logic             whilo,
    input  logic [31:0]      hi_i,
    input  logic [31:0]      lo_i,
    output logic [31:0]      hi_o,
    output logic [31:0]      lo_o,
    output logic [CNT_W-1:0] commit_cnt
);
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic [31:0]      regs_q [NREG];
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_gpr, commit;

    assign wr_gpr = we && (waddr != 5'd0);
    assign commit = wr_gpr || whilo;

    always_comb begin
        hi_d  = whilo ? hi_i : hi_q;
        lo_d  = whilo ? lo_i : lo_q;
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, commit};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (wr_gpr) regs_q[waddr] <= wdata;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_d;
        end
    end

    // $0 and disabled ports read zero; reset masks every read path
    always_comb begin
        rdata1 = (rst || !re1 || raddr1 == 5'd0) ? '0 :
                 (BYP && wr_gpr && raddr1 == waddr) ? wdata : regs_q[raddr1];
        rdata2 = (rst || !re2 || raddr2 == 5'd0) ? '0 :
                 (BYP && wr_gpr && raddr2 == waddr) ? wdata : regs_q[raddr2];
        hi_o   = rst ? '0 : (BYP && whilo) ? hi_i : hi_q;
        lo_o   = rst ? '0 : (BYP && whilo) ? lo_i : lo_q;
    end

    assign commit_cnt = cnt_q;
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: table-driven write-then-read vectors plus reset, bypass and counter-wrap sequences.
module tb_wb_regfile;
    logic        clk = 0;
    logic        rst, we, re1, re2, whilo;
    logic [4:0]  waddr, raddr1, raddr2;
    logic [31:0] wdata, hi_i, lo_i;
    logic [31:0] rdata1, rdata2, hi_o, lo_o, cnt;
    logic [31:0] s_r1, s_r2, s_hi, s_lo;
    logic [3:0]  cnt4;
    int          n_run = 0, n_fail = 0;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .whilo(whilo), .hi_i(hi_i), .lo_i(lo_i), .hi_o(hi_o), .lo_o(lo_o),
        .commit_cnt(cnt)
    );

    wb_regfile #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .raddr1(raddr1), .rdata1(s_r1),
        .re2(re2), .raddr2(raddr2), .rdata2(s_r2),
        .whilo(whilo), .hi_i(hi_i), .lo_i(lo_i), .hi_o(s_hi), .lo_o(s_lo),
        .commit_cnt(cnt4)
    );

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi, lo;
        logic        re1;
        logic [4:0]  raddr1;
        logic        re2;
        logic [4:0]  raddr2;
        logic [31:0] e_r1, e_r2, e_hi, e_lo, e_cnt;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        we = 0; waddr = 0; wdata = 0; whilo = 0; hi_i = 0; lo_i = 0;
        re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    initial begin
        // write phase fields, then read phase fields with expected outputs
        tbl[0] = '{1, 5,  32'hDEADBEEF, 0, 0, 0, 1, 5,  1, 5,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 1};
        tbl[1] = '{0, 5,  32'h0,        0, 0, 0, 0, 5,  1, 5,  0, 32'hDEADBEEF, 0, 0, 1};
        tbl[2] = '{1, 0,  32'hFFFFFFFF, 0, 0, 0, 1, 0,  1, 5,  0, 32'hDEADBEEF, 0, 0, 1};
        tbl[3] = '{1, 3,  32'hC,        1, 32'hA, 32'hB, 1, 3, 1, 0, 32'hC, 0, 32'hA, 32'hB, 2};
        tbl[4] = '{1, 31, 32'h80000001, 0, 0, 0, 1, 31, 1, 3, 32'h80000001, 32'hC, 32'hA, 32'hB, 3};
        tbl[5] = '{0, 0,  32'h0,        1, 32'h1111, 32'h2222, 1, 5, 1, 31, 32'hDEADBEEF, 32'h80000001, 32'h1111, 32'h2222, 4};
        tbl[6] = '{1, 3,  32'h0,        0, 0, 0, 1, 3,  1, 3,  0, 0, 32'h1111, 32'h2222, 5};

        // reset: all indices on both ports read zero
        do_reset();
        for (int i = 0; i < 32; i++) begin
            re1 = 1; raddr1 = 5'(i); re2 = 1; raddr2 = 5'(31 - i);
            #1;
            chk($sformatf("rst_r1[%0d]", i), rdata1, 0);
            chk($sformatf("rst_r2[%0d]", 31 - i), rdata2, 0);
        end
        chk("rst_hi", hi_o, 0);
        chk("rst_lo", lo_o, 0);
        chk("rst_cnt", cnt, 0);
        idle();

        foreach (tbl[k]) begin
            we = tbl[k].we; waddr = tbl[k].waddr; wdata = tbl[k].wdata;
            whilo = tbl[k].whilo; hi_i = tbl[k].hi; lo_i = tbl[k].lo;
            tick();
            idle();
            re1 = tbl[k].re1; raddr1 = tbl[k].raddr1;
            re2 = tbl[k].re2; raddr2 = tbl[k].raddr2;
            #2;
            chk($sformatf("v%0d_r1", k), rdata1, tbl[k].e_r1);
            chk($sformatf("v%0d_r2", k), rdata2, tbl[k].e_r2);
            chk($sformatf("v%0d_hi", k), hi_o, tbl[k].e_hi);
            chk($sformatf("v%0d_lo", k), lo_o, tbl[k].e_lo);
            chk($sformatf("v%0d_cnt", k), cnt, tbl[k].e_cnt);
        end
        chk("cnt4_mod", {28'h0, cnt4}, 5);

        // same-cycle write and read of reg 7 and HI/LO
        idle();
        we = 1; waddr = 7; wdata = 32'h12345678; re2 = 1; raddr2 = 7;
        whilo = 1; hi_i = 32'h77; lo_i = 32'h88;
        #2;
`ifdef WB_BYPASS_EN
        chk("byp_r2", rdata2, 32'h12345678);
        chk("byp_hi", hi_o, 32'h77);
        chk("byp_lo", lo_o, 32'h88);
`else
        chk("byp_r2", rdata2, 0);
        chk("byp_hi", hi_o, 32'h1111);
        chk("byp_lo", lo_o, 32'h2222);
`endif
        tick();
        idle(); re2 = 1; raddr2 = 7;
        #2;
        chk("post_r2", rdata2, 32'h12345678);
        chk("post_hi", hi_o, 32'h77);
        chk("post_cnt", cnt, 6);

        // reset asserted on the same edge as a write
        idle();
        re1 = 1; raddr1 = 7;
        rst = 1; we = 1; waddr = 9; wdata = 32'h55;
        #2;
        chk("rstm_force_r1", rdata1, 0);
        chk("rstm_force_hi", hi_o, 0);
        tick();
        rst = 0; idle();
        re1 = 1; raddr1 = 9; re2 = 1; raddr2 = 7;
        #2;
        chk("rstm_r9", rdata1, 0);
        chk("rstm_r7", rdata2, 0);
        chk("rstm_cnt", cnt, 0);
        chk("rstm_cnt4", {28'h0, cnt4}, 0);

        // 16 commits wrap the 4-bit counter; both sources at once count once
        for (int i = 0; i < 16; i++) begin
            idle();
            we = 1; waddr = 5'(i + 1); wdata = 32'(i); whilo = (i % 3 == 0);
            tick();
        end
        idle();
        #1;
        chk("wrap_cnt4", {28'h0, cnt4}, 0);
        chk("wrap_cnt", cnt, 16);
        whilo = 1;
        tick();
        idle();
        #1;
        chk("wrap_cnt4_p1", {28'h0, cnt4}, 1);
        re1 = 1; raddr1 = 16;
        #1;
        chk("wrap_r16", rdata1, 15);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
